// File: rtl/fib_pkg.sv
// Shared types and helpers for the NDN FIB longest-prefix-match table.
// Optional feature macro used by the table: FIB_RR_REPLACE_EN.
package fib_pkg;

   localparam int unsigned FIB_PREFIX_W = 64;
   localparam int unsigned FIB_LEN_W    = 7;
   localparam int unsigned FIB_FACE_W   = 4;
   localparam int unsigned FIB_DEPTH    = 16;
   localparam int unsigned FIB_MAX_W    = 128;

   typedef struct packed {
      logic                    valid;
      logic [FIB_PREFIX_W-1:0] prefix;
      logic [FIB_LEN_W-1:0]    len;
      logic [FIB_FACE_W-1:0]   face;
   } fib_entry_t;

   typedef enum logic [2:0] {
      IDLE,
      LSCAN,
      RESP,
      WSCAN,
      WRITE
   } fib_state_t;

   // Ones in the top 'len' bits of a 'width'-bit field (low-aligned in the result).
   function automatic logic [FIB_MAX_W-1:0] len_to_mask(input int unsigned len,
                                                       input int unsigned width);
      logic [FIB_MAX_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < FIB_MAX_W; i++) begin
         m[i] = (i < width) && ((i + len) >= width);
      end
      return m;
   endfunction

   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned width);
      return (len > width) ? width : len;
   endfunction

endpackage

// File: rtl/fib_prefix_match.sv
// Combinational compare of one stored route against a lookup/write key.
// o_match: route covers the key; o_exact: same (prefix, len).
module fib_prefix_match
   import fib_pkg::*;
#(
   parameter int unsigned PREFIX_W = 64,
   parameter int unsigned LEN_W    = 7
) (
   input  logic                i_e_valid,
   input  logic [PREFIX_W-1:0] i_e_prefix,
   input  logic [LEN_W-1:0]    i_e_len,
   input  logic [PREFIX_W-1:0] i_k_prefix,
   input  logic [LEN_W-1:0]    i_k_len,
   output logic                o_match,
   output logic                o_exact
);

   logic [PREFIX_W-1:0] w_mask;

   always_comb begin
      w_mask  = PREFIX_W'(len_to_mask(32'(i_e_len), PREFIX_W));
      o_match = i_e_valid && (i_e_len <= i_k_len) &&
                (((i_e_prefix ^ i_k_prefix) & w_mask) == '0);
      o_exact = i_e_valid && (i_e_len == i_k_len) && (i_e_prefix == i_k_prefix);
   end

endmodule

// File: rtl/fib_lpm_table.sv
// FIB route table: sequential-scan longest-prefix-match lookup plus insert/update/delete.
// Define FIB_RR_REPLACE_EN to overwrite a round-robin victim when inserting into a full table.
module fib_lpm_table
   import fib_pkg::*;
#(
   parameter int unsigned PREFIX_W = 64,
   parameter int unsigned LEN_W    = 7,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned FACE_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       lkp_valid,
   output logic                       lkp_ready,
   input  logic [PREFIX_W-1:0]        lkp_prefix,
   input  logic [LEN_W-1:0]           lkp_len,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic                       rsp_hit,
   output logic [PREFIX_W-1:0]        rsp_prefix,
   output logic [LEN_W-1:0]           rsp_len,
   output logic [FACE_W-1:0]          rsp_face,
   input  logic                       ins_valid,
   output logic                       ins_ready,
   input  logic                       ins_del,
   input  logic [PREFIX_W-1:0]        ins_prefix,
   input  logic [LEN_W-1:0]           ins_len,
   input  logic [FACE_W-1:0]          ins_face,
   output logic                       ins_done,
   output logic                       ins_err,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH+1);

   fib_state_t r_state, w_next;
   logic       r_live;

   logic                r_valid  [DEPTH];
   logic [PREFIX_W-1:0] r_prefix [DEPTH];
   logic [LEN_W-1:0]    r_len    [DEPTH];
   logic [FACE_W-1:0]   r_face   [DEPTH];

   logic [IDX_W-1:0]    r_idx;
   logic [PREFIX_W-1:0] r_key_prefix;
   logic [LEN_W-1:0]    r_key_len;
   logic [FACE_W-1:0]   r_key_face;
   logic                r_key_del;

   logic                r_best_hit;
   logic [PREFIX_W-1:0] r_best_prefix;
   logic [LEN_W-1:0]    r_best_len;
   logic [FACE_W-1:0]   r_best_face;

   logic                r_exact_found, r_free_found;
   logic [IDX_W-1:0]    r_exact_idx, r_free_idx;

   logic                r_rsp_valid, r_rsp_hit;
   logic [PREFIX_W-1:0] r_rsp_prefix;
   logic [LEN_W-1:0]    r_rsp_len;
   logic [FACE_W-1:0]   r_rsp_face;
   logic [OCC_W-1:0]    r_occ;

   logic                w_last, w_ins_acc, w_lkp_acc, w_match, w_exact;
   logic [LEN_W-1:0]    w_acc_len;
   logic [PREFIX_W-1:0] w_acc_prefix;
   logic                w_do_upd, w_do_fill, w_do_del, w_do_repl, w_err, w_wr_en;
   logic [IDX_W-1:0]    w_wr_idx;

   assign w_last    = (r_idx == IDX_W'(DEPTH-1));
   assign ins_ready = r_live && (r_state == IDLE);
   assign lkp_ready = r_live && (r_state == IDLE) && !ins_valid;
   assign w_ins_acc = ins_valid && ins_ready;
   assign w_lkp_acc = lkp_valid && lkp_ready;

   // Accepted key is normalised once: length clamped, bits below length zeroed.
   assign w_acc_len    = LEN_W'(clamp_len(32'(w_ins_acc ? ins_len : lkp_len), PREFIX_W));
   assign w_acc_prefix = (w_ins_acc ? ins_prefix : lkp_prefix) &
                         PREFIX_W'(len_to_mask(32'(w_acc_len), PREFIX_W));

   fib_prefix_match #(
      .PREFIX_W(PREFIX_W),
      .LEN_W   (LEN_W)
   ) u_match (
      .i_e_valid (r_valid[r_idx]),
      .i_e_prefix(r_prefix[r_idx]),
      .i_e_len   (r_len[r_idx]),
      .i_k_prefix(r_key_prefix),
      .i_k_len   (r_key_len),
      .o_match   (w_match),
      .o_exact   (w_exact)
   );

   assign w_do_upd  = !r_key_del && r_exact_found;
   assign w_do_fill = !r_key_del && !r_exact_found && r_free_found;
   assign w_do_del  = r_key_del && r_exact_found;

`ifdef FIB_RR_REPLACE_EN
   logic [IDX_W-1:0] r_victim;

   assign w_do_repl = !r_key_del && !r_exact_found && !r_free_found;
   assign w_err     = r_key_del && !r_exact_found;
   assign w_wr_idx  = w_do_upd ? r_exact_idx : (w_do_fill ? r_free_idx : r_victim);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_victim <= '0;
      end else if ((r_state == WRITE) && w_do_repl) begin
         r_victim <= (r_victim == IDX_W'(DEPTH-1)) ? '0 : r_victim + IDX_W'(1);
      end
   end
`else
   assign w_do_repl = 1'b0;
   assign w_err     = r_key_del ? !r_exact_found : (!r_exact_found && !r_free_found);
   assign w_wr_idx  = w_do_upd ? r_exact_idx : r_free_idx;
`endif

   assign w_wr_en = (r_state == WRITE) && (w_do_upd || w_do_fill || w_do_repl);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_ins_acc) w_next = WSCAN;
                  else if (w_lkp_acc) w_next = LSCAN;
         LSCAN:   if (w_last) w_next = RESP;
         RESP:    if (r_rsp_valid && rsp_ready) w_next = IDLE;
         WSCAN:   if (w_last) w_next = WRITE;
         WRITE:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
      end else if (r_state == WRITE) begin
         if (w_wr_en)       r_valid[w_wr_idx]    <= 1'b1;
         else if (w_do_del) r_valid[r_exact_idx] <= 1'b0;
      end
   end

   // Route payload needs no reset; only the valid bits define table contents.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_prefix[w_wr_idx] <= r_key_prefix;
         r_len[w_wr_idx]    <= r_key_len;
         r_face[w_wr_idx]   <= r_key_face;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_live        <= 1'b0;
         r_idx         <= '0;
         r_key_prefix  <= '0;
         r_key_len     <= '0;
         r_key_face    <= '0;
         r_key_del     <= 1'b0;
         r_best_hit    <= 1'b0;
         r_best_prefix <= '0;
         r_best_len    <= '0;
         r_best_face   <= '0;
         r_exact_found <= 1'b0;
         r_exact_idx   <= '0;
         r_free_found  <= 1'b0;
         r_free_idx    <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_hit     <= 1'b0;
         r_rsp_prefix  <= '0;
         r_rsp_len     <= '0;
         r_rsp_face    <= '0;
         r_occ         <= '0;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_ins_acc || w_lkp_acc) begin
                  r_key_prefix  <= w_acc_prefix;
                  r_key_len     <= w_acc_len;
                  r_key_face    <= ins_face;
                  r_key_del     <= w_ins_acc && ins_del;
                  r_idx         <= '0;
                  r_best_hit    <= 1'b0;
                  r_best_prefix <= '0;
                  r_best_len    <= '0;
                  r_best_face   <= '0;
                  r_exact_found <= 1'b0;
                  r_free_found  <= 1'b0;
               end
            end
            LSCAN: begin
               if (w_match && (!r_best_hit || (r_len[r_idx] > r_best_len))) begin
                  r_best_hit    <= 1'b1;
                  r_best_prefix <= r_prefix[r_idx];
                  r_best_len    <= r_len[r_idx];
                  r_best_face   <= r_face[r_idx];
               end
               r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end
            RESP: begin
               if (!r_rsp_valid) begin
                  r_rsp_valid  <= 1'b1;
                  r_rsp_hit    <= r_best_hit;
                  r_rsp_prefix <= r_best_prefix;
                  r_rsp_len    <= r_best_len;
                  r_rsp_face   <= r_best_face;
               end else if (rsp_ready) begin
                  r_rsp_valid  <= 1'b0;
                  r_rsp_hit    <= 1'b0;
                  r_rsp_prefix <= '0;
                  r_rsp_len    <= '0;
                  r_rsp_face   <= '0;
               end
            end
            WSCAN: begin
               if (w_exact && !r_exact_found) begin
                  r_exact_found <= 1'b1;
                  r_exact_idx   <= r_idx;
               end
               if (!r_valid[r_idx] && !r_free_found) begin
                  r_free_found <= 1'b1;
                  r_free_idx   <= r_idx;
               end
               r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end
            WRITE: begin
               if (w_do_fill)     r_occ <= r_occ + OCC_W'(1);
               else if (w_do_del) r_occ <= r_occ - OCC_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid  = r_rsp_valid;
   assign rsp_hit    = r_rsp_hit;
   assign rsp_prefix = r_rsp_prefix;
   assign rsp_len    = r_rsp_len;
   assign rsp_face   = r_rsp_face;
   assign ins_done   = (r_state == WRITE);
   assign ins_err    = ins_done && w_err;
   assign occupancy  = r_occ;

endmodule
